// File: rtl/sipo_deserializer_pkg.sv
// Shared constants and types for the serial-in parallel-out receiver.
// The default word width matches the transmit side of the link.
package sipo_deserializer_pkg;

    localparam int SIPO_WORD_W = 8;

    // One-deep output buffer occupancy; BUF_FULL is what drives valid_o.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial link input plus word-wide output bus of the SIPO receiver.
// Handshake: a word transfers on any rising edge where valid_o = 1 and ready_i = 1.
interface sipo_deserializer_if
    import sipo_deserializer_pkg::*;
#(
    parameter int N = SIPO_WORD_W
);
    localparam int CNT_W = $clog2(N);

    logic             serial_i;
    logic             bit_valid_i;
    logic             sync_i;
    logic             ready_i;
    logic             clr_ovf_i;
    logic [N-1:0]     parallel_o;
    logic             valid_o;
    logic             overflow_o;
    logic [CNT_W-1:0] bit_cnt_o;

    modport master (
        output serial_i, bit_valid_i, sync_i, ready_i, clr_ovf_i,
        input  parallel_o, valid_o, overflow_o, bit_cnt_o
    );

    modport slave (
        input  serial_i, bit_valid_i, sync_i, ready_i, clr_ovf_i,
        output parallel_o, valid_o, overflow_o, bit_cnt_o
    );

endinterface

// File: rtl/sipo_deserializer_shift_core.sv
// MSB-first shift register with bit counter; pulses o_done on the edge that
// receives the last bit of a word and presents the assembled word on o_word.
module sipo_deserializer_shift_core #(
    parameter int N = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 i_serial,
    input  logic                 i_bit_valid,
    input  logic                 i_sync,
    output logic [N-1:0]         o_word,
    output logic                 o_done,
    output logic [$clog2(N)-1:0] o_bit_cnt
);
    localparam int CNT_W = $clog2(N);

    logic [N-1:0]     r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;
    logic [N-1:0]     w_word;

    always_comb begin
        w_last = (r_cnt == CNT_W'(N - 1));
        w_word = {r_shift[N-2:0], i_serial};
    end

    // Explicit wrap at N-1 so non-power-of-two widths count correctly.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_sync) begin
            r_shift <= i_bit_valid ? {{(N-1){1'b0}}, i_serial} : '0;
            r_cnt   <= i_bit_valid ? CNT_W'(1) : '0;
        end else if (i_bit_valid) begin
            r_shift <= w_word;
            r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Sync on a would-be completion edge suppresses the word entirely.
    assign o_done    = i_bit_valid & w_last & ~i_sync;
    assign o_word    = w_word;
    assign o_bit_cnt = r_cnt;

endmodule

// File: rtl/sipo_deserializer.sv
// SIPO receiver top: shift core feeding a one-deep valid/ready output buffer
// with a sticky overflow flag for words that arrive while the buffer is held.
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int N = SIPO_WORD_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    sipo_deserializer_if.slave bus
);
    localparam int CNT_W = $clog2(N);

    logic [N-1:0]     w_word;
    logic             w_done;
    logic [CNT_W-1:0] w_bit_cnt;

    buf_state_e       r_buf_state;
    buf_state_e       w_buf_next;
    logic [N-1:0]     r_parallel;
    logic             r_ovf;
    logic             w_load;
    logic             w_drop;

    sipo_deserializer_shift_core #(
        .N (N)
    ) u_core (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_serial    (bus.serial_i),
        .i_bit_valid (bus.bit_valid_i),
        .i_sync      (bus.sync_i),
        .o_word      (w_word),
        .o_done      (w_done),
        .o_bit_cnt   (w_bit_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_buf_state <= BUF_EMPTY;
        end else begin
            r_buf_state <= w_buf_next;
        end
    end

    // A completion coinciding with a handshake refills the slot in place.
    always_comb begin
        w_buf_next = r_buf_state;
        w_load     = 1'b0;
        w_drop     = 1'b0;
        case (r_buf_state)
            BUF_EMPTY: begin
                if (w_done) begin
                    w_load     = 1'b1;
                    w_buf_next = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (w_done) begin
                    if (bus.ready_i) w_load = 1'b1;
                    else             w_drop = 1'b1;
                end else if (bus.ready_i) begin
                    w_buf_next = BUF_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_parallel <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_load) r_parallel <= w_word;
            // A fresh drop outranks a simultaneous clear.
            if (w_drop)             r_ovf <= 1'b1;
            else if (bus.clr_ovf_i) r_ovf <= 1'b0;
        end
    end

    assign bus.parallel_o = r_parallel;
    assign bus.valid_o    = (r_buf_state == BUF_FULL);
    assign bus.overflow_o = r_ovf;
    assign bus.bit_cnt_o  = w_bit_cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: N=8 and N=10 instances share one stimulus stream
// and are compared every cycle against a word-level model of the receiver.
module tb_sipo_deserializer;

  logic clk;
  logic rst_n;
  logic chk_en;

  int total;
  int bad;

  sipo_deserializer_if #(.N(8))  if8 ();
  sipo_deserializer_if #(.N(10)) if10 ();

  sipo_deserializer #(.N(8)) u_dut8 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (if8)
  );

  sipo_deserializer #(.N(10)) u_dut10 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (if10)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  int          m_cnt[2];
  logic [15:0] m_acc[2];
  logic [15:0] m_par[2];
  bit          m_valid[2];
  bit          m_ovf[2];
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]   = 0;
      m_acc[k]   = '0;
      m_par[k]   = '0;
      m_valid[k] = 1'b0;
      m_ovf[k]   = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Word-level receiver rules: value accumulates as acc*2+bit modulo 2^n.
  task automatic model_step(input int k, input int n, input bit ser, input bit bv,
                            input bit sy, input bit rdy, input bit clr,
                            input logic [15:0] dut_par);
    bit          done;
    bit          fire;
    bit          drop;
    logic [15:0] mask;
    logic [15:0] got;
    mask = 16'((32'd1 << n) - 1);
    done = 1'b0;
    drop = 1'b0;
    if (sy) begin
      m_acc[k] = bv ? 16'(ser) : 16'h0;
      m_cnt[k] = bv ? 1 : 0;
    end else if (bv) begin
      m_acc[k] = ((m_acc[k] << 1) | 16'(ser)) & mask;
      m_cnt[k] = m_cnt[k] + 1;
      if (m_cnt[k] == n) begin
        done     = 1'b1;
        m_cnt[k] = 0;
      end
    end
    fire = m_valid[k] && rdy;
    if (fire) begin
      if (k == 0) begin
        if (exp_q0.size() == 0) begin chk("sb_empty8", 32'd1, 32'd0); got = '0; end
        else got = exp_q0.pop_front();
      end else begin
        if (exp_q1.size() == 0) begin chk("sb_empty10", 32'd1, 32'd0); got = '0; end
        else got = exp_q1.pop_front();
      end
      chk(k == 0 ? "sb_word8" : "sb_word10", 32'(dut_par), 32'(got));
    end
    if (done && (!m_valid[k] || fire)) begin
      m_par[k]   = m_acc[k];
      m_valid[k] = 1'b1;
      if (k == 0) exp_q0.push_back(m_acc[k]);
      else        exp_q1.push_back(m_acc[k]);
    end else if (done) begin
      drop = 1'b1;
    end else if (fire) begin
      m_valid[k] = 1'b0;
    end
    if (drop)     m_ovf[k] = 1'b1;
    else if (clr) m_ovf[k] = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit ser, input bit bv, input bit sy, input bit rdy, input bit clr);
    logic [15:0] p0;
    logic [15:0] p1;
    @(negedge clk);
    if8.serial_i     = ser;  if10.serial_i    = ser;
    if8.bit_valid_i  = bv;   if10.bit_valid_i = bv;
    if8.sync_i       = sy;   if10.sync_i      = sy;
    if8.ready_i      = rdy;  if10.ready_i     = rdy;
    if8.clr_ovf_i    = clr;  if10.clr_ovf_i   = clr;
    p0 = 16'(if8.parallel_o);
    p1 = 16'(if10.parallel_o);
    @(posedge clk);
    model_step(0, 8,  ser, bv, sy, rdy, clr, p0);
    model_step(1, 10, ser, bv, sy, rdy, clr, p1);
  endtask

  task automatic send_word(input logic [15:0] w, input int n, input bit rdy_rest, input bit rdy_last);
    for (int i = n - 1; i >= 0; i--) begin
      cyc(w[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy_rest, 1'b0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_par8"},  32'(if8.parallel_o),  32'd0);
    chk({tag, "_val8"},  32'(if8.valid_o),     32'd0);
    chk({tag, "_ovf8"},  32'(if8.overflow_o),  32'd0);
    chk({tag, "_cnt8"},  32'(if8.bit_cnt_o),   32'd0);
    chk({tag, "_par10"}, 32'(if10.parallel_o), 32'd0);
    chk({tag, "_val10"}, 32'(if10.valid_o),    32'd0);
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero(tag);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("par8",  32'(if8.parallel_o),  32'(m_par[0][7:0]));
      chk("val8",  32'(if8.valid_o),     32'(m_valid[0]));
      chk("ovf8",  32'(if8.overflow_o),  32'(m_ovf[0]));
      chk("cnt8",  32'(if8.bit_cnt_o),   32'(m_cnt[0]));
      chk("par10", 32'(if10.parallel_o), 32'(m_par[1][9:0]));
      chk("val10", 32'(if10.valid_o),    32'(m_valid[1]));
      chk("ovf10", 32'(if10.overflow_o), 32'(m_ovf[1]));
      chk("cnt10", 32'(if10.bit_cnt_o),  32'(m_cnt[1]));
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] w;
    total  = 0;
    bad    = 0;
    chk_en = 1'b0;
    rst_n  = 1'b1;
    if8.serial_i = 0;  if8.bit_valid_i = 0;  if8.sync_i = 0;  if8.ready_i = 0;  if8.clr_ovf_i = 0;
    if10.serial_i = 0; if10.bit_valid_i = 0; if10.sync_i = 0; if10.ready_i = 0; if10.clr_ovf_i = 0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst0");
    #20 rst_n = 1'b1;
    chk_en = 1'b1;

    // A5 with ready high throughout
    send_word(16'h00A5, 8, 1'b1, 1'b1);
    #1;
    chk("a5_par", 32'(if8.parallel_o), 32'h0A5);
    chk("a5_val", 32'(if8.valid_o), 32'd1);
    chk("a5_cnt", 32'(if8.bit_cnt_o), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("a5_drop_val", 32'(if8.valid_o), 32'd0);

    // 3C then C3 with no consumer: second word dropped
    send_word(16'h003C, 8, 1'b0, 1'b0);
    send_word(16'h00C3, 8, 1'b0, 1'b0);
    #1;
    chk("ovf_par", 32'(if8.parallel_o), 32'h3C);
    chk("ovf_val", 32'(if8.valid_o), 32'd1);
    chk("ovf_flag", 32'(if8.overflow_o), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("ovf_drain", 32'(if8.valid_o), 32'd0);
    chk("ovf_sticky", 32'(if8.overflow_o), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 chk("ovf_clr", 32'(if8.overflow_o), 32'd0);

    // Continuous stream, ready only on each completion edge
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int j = 0; j < 4; j++) begin
      w = 16'($urandom_range(0, 255));
      send_word(w, 8, 1'b0, 1'b1);
      #1 chk("cont_word", 32'(if8.parallel_o), 32'(w[7:0]));
    end
    chk("cont_ovf", 32'(if8.overflow_o), 32'd0);

    // Sync mid-word with a coincident strobe
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 5; j++) cyc(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("sync_cnt", 32'(if8.bit_cnt_o), 32'd1);
    chk("sync_noemit", 32'(if8.valid_o), 32'd0);
    for (int j = 0; j < 7; j++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("sync_ff", 32'(if8.parallel_o), 32'hFF);

    // Reset mid-word, then reset while a word is buffered
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int j = 0; j < 4; j++) cyc(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0);
    async_reset("rst_mid");
    send_word(16'h005A, 8, 1'b0, 1'b0);
    #1 chk("pre_rst_val", 32'(if8.valid_o), 32'd1);
    async_reset("rst_full");
    w = 16'($urandom_range(0, 255));
    send_word(w, 8, 1'b0, 1'b0);
    #1 chk("post_rst_word", 32'(if8.parallel_o), 32'(w[7:0]));

    // N=10 word with counter wrap 9 -> 0
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    w = 16'h02B7;
    for (int i = 9; i >= 1; i--) cyc(w[i], 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("n10_cnt9", 32'(if10.bit_cnt_o), 32'd9);
    cyc(w[0], 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("n10_par", 32'(if10.parallel_o), 32'h2B7);
    chk("n10_cnt0", 32'(if10.bit_cnt_o), 32'd0);
    chk("n10_val", 32'(if10.valid_o), 32'd1);

    // Randomized traffic
    for (int j = 0; j < 2000; j++) begin
      cyc(1'($urandom_range(0, 1)),
          $urandom_range(0, 99) < 70,
          $urandom_range(0, 99) < 3,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 99) < 5);
    end
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
